mshr_multi_lookup: RTL

- Next-generation miss status holding register (MSHR) for one cache bank. It tracks outstanding line misses and the per-request metadata attached to each.
- Generalised from the single-lookup MSHR in four ways:
  - NUM_LOOKUPS parallel lookup ports.
  - A first-class per-entry prefetch flag, with demand promotion.
  - Reserved capacity that only demand allocations may use.
  - Occupancy and prefetch-occupancy counters.
- Sits between the bank tag-check stage (allocate, lookup), the memory response path (fill, replay) and the bank replay pipeline (dequeue, release).

---
 rtl/mshr_multi_lookup.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mshr_multi_lookup.sv
// mshr_multi_lookup
// Miss status holding register for one cache bank. Tracks outstanding line
// misses plus per-request metadata, with several parallel lookup ports, a
// per-entry prefetch flag that demand traffic can promote away, capacity held
// back from prefetches, and occupancy counters.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   allocate_*                 miss allocation from tag check; allocate_id is
//                              the entry the next accepted allocation fills
//   fill_valid/fill_id         memory response; fill_addr reads that entry
//   replay_valid/replay_addr   mark every valid entry at that line ready
//   lookup_addr/lookup_id      per-port address probe, excluding one entry
//   lookup_match/_pf_match     per-port hit and hit-on-prefetch flags
//   promote_valid/promote_id   clear an entry's prefetch flag
//   dequeue_*                  lowest-index ready entry, valid/ready handshake
//   release_valid/release_id   free an entry
//   count/pf_count/full/empty  occupancy status
module mshr_multi_lookup #(
   parameter int MSHR_SIZE       = 8,
   parameter int LINE_ADDR_WIDTH = 26,
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_LOOKUPS     = 2,
   parameter int PF_RESERVE      = 2,
   parameter int IDW             = $clog2(MSHR_SIZE),
   parameter int CNTW            = $clog2(MSHR_SIZE + 1)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 allocate_valid,
   input  logic                                 allocate_prefetch,
   input  logic [LINE_ADDR_WIDTH-1:0]           allocate_addr,
   input  logic [DATA_WIDTH-1:0]                allocate_data,
   output logic                                 allocate_ready,
   output logic [IDW-1:0]                       allocate_id,
   input  logic                                 fill_valid,
   input  logic [IDW-1:0]                       fill_id,
   output logic [LINE_ADDR_WIDTH-1:0]           fill_addr,
   input  logic                                 replay_valid,
   input  logic [LINE_ADDR_WIDTH-1:0]           replay_addr,
   input  logic [NUM_LOOKUPS*LINE_ADDR_WIDTH-1:0] lookup_addr,
   input  logic [NUM_LOOKUPS*IDW-1:0]           lookup_id,
   output logic [NUM_LOOKUPS-1:0]               lookup_match,
   output logic [NUM_LOOKUPS-1:0]               lookup_pf_match,
   input  logic                                 promote_valid,
   input  logic [IDW-1:0]                       promote_id,
   output logic                                 dequeue_valid,
   output logic [IDW-1:0]                       dequeue_id,
   output logic [LINE_ADDR_WIDTH-1:0]           dequeue_addr,
   output logic [DATA_WIDTH-1:0]                dequeue_data,
   output logic                                 dequeue_prefetch,
   input  logic                                 dequeue_ready,
   input  logic                                 release_valid,
   input  logic [IDW-1:0]                       release_id,
   output logic [CNTW-1:0]                      count,
   output logic [CNTW-1:0]                      pf_count,
   output logic                                 full,
   output logic                                 empty
);

   logic [MSHR_SIZE-1:0]       valid_q, ready_q, pf_q;
   logic [MSHR_SIZE-1:0]       valid_n, ready_n, pf_n;
   logic [LINE_ADDR_WIDTH-1:0] addr_q [MSHR_SIZE];
   logic [DATA_WIDTH-1:0]      data_q [MSHR_SIZE];
   logic [CNTW-1:0]            count_q, count_n, pf_count_q, pf_count_n;
   logic [CNTW-1:0]            free_cnt;
   logic                       dequeue_valid_q, dequeue_valid_n;
   logic [IDW-1:0]             dequeue_id_q, dequeue_id_n;
   logic [IDW-1:0]             alloc_id_q, alloc_id_n;
   logic                       alloc_fire, dequeue_fire, release_eff, promote_eff;

   // Prefetches may not consume the last PF_RESERVE free entries, so demand
   // misses can always make progress even under a prefetch flood.
   assign free_cnt       = CNTW'(MSHR_SIZE) - count_q;
   assign allocate_ready = allocate_prefetch ? (free_cnt > CNTW'(PF_RESERVE))
                                             : (free_cnt != '0);
   assign alloc_fire     = allocate_valid & allocate_ready;
   assign dequeue_fire   = dequeue_valid_q & dequeue_ready;
   assign release_eff    = release_valid & valid_q[release_id];
   // A promote that collides with a release of the same entry is absorbed by
   // the release, so pf_count drops only once.
   assign promote_eff    = promote_valid & valid_q[promote_id] & pf_q[promote_id]
                         & ~(release_eff & (release_id == promote_id));

   // Next-state entry table. Later assignments take priority: fill and replay
   // re-set ready after a dequeue clear, and release overrides everything.
   always_comb begin
      valid_n = valid_q;
      ready_n = ready_q;
      pf_n    = pf_q;
      if (alloc_fire) begin
         valid_n[alloc_id_q] = 1'b1;
         ready_n[alloc_id_q] = 1'b0;
         pf_n[alloc_id_q]    = allocate_prefetch;
      end
      if (dequeue_fire) begin
         ready_n[dequeue_id_q] = 1'b0;
      end
      if (fill_valid) begin
         ready_n[fill_id] = 1'b1;
      end
      if (replay_valid) begin
         for (int i = 0; i < MSHR_SIZE; i++) begin
            if (valid_q[i] && (addr_q[i] == replay_addr)) begin
               ready_n[i] = 1'b1;
            end
         end
      end
      if (promote_eff) begin
         pf_n[promote_id] = 1'b0;
      end
      if (release_eff) begin
         valid_n[release_id] = 1'b0;
         ready_n[release_id] = 1'b0;
         pf_n[release_id]    = 1'b0;
      end
   end

   // Counters apply the net effect of everything that happens in one cycle.
   always_comb begin
      count_n    = count_q + CNTW'(alloc_fire) - CNTW'(release_eff);
      pf_count_n = pf_count_q + CNTW'(alloc_fire & allocate_prefetch)
                 - CNTW'(release_eff & pf_q[release_id]) - CNTW'(promote_eff);
   end

   // Lowest free slot and lowest ready slot are chosen from the next-state
   // table so both can be registered and presented a cycle later with no
   // priority encoder on the output path. The descending scan leaves the
   // lowest matching index as the final assignment.
   always_comb begin
      alloc_id_n      = '0;
      dequeue_valid_n = 1'b0;
      dequeue_id_n    = '0;
      for (int i = MSHR_SIZE - 1; i >= 0; i--) begin
         if (!valid_n[i]) begin
            alloc_id_n = IDW'(i);
         end
         if (valid_n[i] && ready_n[i]) begin
            dequeue_valid_n = 1'b1;
            dequeue_id_n    = IDW'(i);
         end
      end
   end

   // Lookup ports see only registered state; each port ignores the entry it
   // names so a request can probe for other misses to its own line.
   always_comb begin
      lookup_match    = '0;
      lookup_pf_match = '0;
      for (int k = 0; k < NUM_LOOKUPS; k++) begin
         for (int i = 0; i < MSHR_SIZE; i++) begin
            if (valid_q[i]
                && (addr_q[i] == lookup_addr[k*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH])
                && (IDW'(i) != lookup_id[k*IDW +: IDW])) begin
               lookup_match[k] = 1'b1;
               if (pf_q[i]) begin
                  lookup_pf_match[k] = 1'b1;
               end
            end
         end
      end
   end

   // Control state: cleared asynchronously so a reset mid-burst drops all
   // outstanding misses immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q         <= '0;
         ready_q         <= '0;
         pf_q            <= '0;
         count_q         <= '0;
         pf_count_q      <= '0;
         dequeue_valid_q <= 1'b0;
         dequeue_id_q    <= '0;
         alloc_id_q      <= '0;
      end else begin
         valid_q         <= valid_n;
         ready_q         <= ready_n;
         pf_q            <= pf_n;
         count_q         <= count_n;
         pf_count_q      <= pf_count_n;
         dequeue_valid_q <= dequeue_valid_n;
         dequeue_id_q    <= dequeue_id_n;
         alloc_id_q      <= alloc_id_n;
      end
   end

   // Payload storage carries no reset; it is only meaningful while valid.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         addr_q[alloc_id_q] <= allocate_addr;
         data_q[alloc_id_q] <= allocate_data;
      end
   end

   assign allocate_id      = alloc_id_q;
   assign fill_addr        = addr_q[fill_id];
   assign dequeue_valid    = dequeue_valid_q;
   assign dequeue_id       = dequeue_id_q;
   assign dequeue_addr     = addr_q[dequeue_id_q];
   assign dequeue_data     = data_q[dequeue_id_q];
   assign dequeue_prefetch = pf_q[dequeue_id_q];
   assign count            = count_q;
   assign pf_count         = pf_count_q;
   assign full             = (count_q == CNTW'(MSHR_SIZE));
   assign empty            = (count_q == '0);

   // Protocol checks: fills and releases must name live entries, and the
   // counters must never wrap.
   fill_of_free_entry: assert property (@(posedge clk) disable iff (reset)
      fill_valid |-> valid_q[fill_id]);
   release_of_free_entry: assert property (@(posedge clk) disable iff (reset)
      release_valid |-> valid_q[release_id]);
   count_overflow: assert property (@(posedge clk) disable iff (reset)
      !(alloc_fire && !release_eff && (count_q == CNTW'(MSHR_SIZE))));
   pf_count_underflow: assert property (@(posedge clk) disable iff (reset)
      !(promote_eff && (pf_count_q == '0)));

endmodule
